ma_unit_pipe: RTL and testbench

//  Multi-lane, pipelined modular add/sub/negate unit with valid/ready flow control.

---
 rtl/ma_pkg.sv | 9 +
 rtl/ma_lane.sv | 43 ++++
 rtl/ma_unit_pipe.sv | 97 +++++++++
 tb/tb_ma_unit_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ma_pkg.sv
// rtl/ma_pkg.sv - op encodings shared by the modular add/sub/negate unit
package ma_pkg;
    localparam int MA_OP_W = 2;

    localparam logic [MA_OP_W-1:0] MA_ADD  = 2'b00;
    localparam logic [MA_OP_W-1:0] MA_SUB  = 2'b01;
    localparam logic [MA_OP_W-1:0] MA_NEG  = 2'b10;
    localparam logic [MA_OP_W-1:0] MA_PASS = 2'b11;
endpackage

// File: rtl/ma_lane.sv
// rtl/ma_lane.sv - one lane of raw W+1-bit arithmetic and single-step modular correction
module ma_lane
    import ma_pkg::*;
#(
    parameter int W = 54
) (
    input  logic [MA_OP_W-1:0] in_op,
    input  logic [W-1:0]       m,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    output logic [W:0]         raw,
    output logic               rerr,
    input  logic [MA_OP_W-1:0] s1_op,
    input  logic [W-1:0]       s1_m,
    input  logic [W:0]         s1_raw,
    output logic [W-1:0]       res
);
    logic [W:0] m_ext;

    assign m_ext = {1'b0, s1_m};

    always_comb begin
        raw = {1'b0, a};
        case (in_op)
            MA_ADD:  raw = {1'b0, a} + {1'b0, b};
            MA_SUB:  raw = {1'b0, a} - {1'b0, b};
            MA_NEG:  raw = {1'b0, m} - {1'b0, b};
            default: raw = {1'b0, a};
        endcase
        rerr = (a >= m) || ((in_op != MA_PASS) && (b >= m));
    end

    // raw[W] on SUB is the borrow; adding m back wraps through the W+1-bit sum
    always_comb begin
        res = s1_raw[W-1:0];
        case (s1_op)
            MA_ADD:  if (s1_raw >= m_ext) res = W'(s1_raw - m_ext);
            MA_SUB:  if (s1_raw[W]) res = W'(s1_raw + m_ext);
            MA_NEG:  if (s1_raw == m_ext) res = '0;
            default: res = s1_raw[W-1:0];
        endcase
    end
endmodule

// File: rtl/ma_unit_pipe.sv
// rtl/ma_unit_pipe.sv - multi-lane two-stage modular add/sub/negate pipeline with valid/ready
module ma_unit_pipe
    import ma_pkg::*;
#(
    parameter int DATA_WIDTH = 54,
    parameter int NUM_LANES  = 4,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [MA_OP_W*NUM_LANES-1:0]    in_op,
    input  logic [DATA_WIDTH-1:0]           in_modulus,
    input  logic [DATA_WIDTH*NUM_LANES-1:0] in_a,
    input  logic [DATA_WIDTH*NUM_LANES-1:0] in_b,
    input  logic [TAG_WIDTH-1:0]            in_tag,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH*NUM_LANES-1:0] out_data,
    output logic [TAG_WIDTH-1:0]            out_tag,
    output logic [NUM_LANES-1:0]            out_rerr
);
    localparam int W = DATA_WIDTH;
    localparam int L = NUM_LANES;

    logic                   s1_v;
    logic                   s2_v;
    logic [MA_OP_W*L-1:0]   s1_op;
    logic [W-1:0]           s1_m;
    logic [TAG_WIDTH-1:0]   s1_tag;
    logic [L-1:0][W:0]      s1_raw;
    logic [L-1:0]           s1_rerr;

    logic [L-1:0][W:0]      lane_raw;
    logic [L-1:0]           lane_rerr;
    logic [W*L-1:0]         lane_res;

    logic                   s2_load;
    logic                   s1_load;

    assign s2_load   = !s2_v || out_ready;
    assign s1_load   = !s1_v || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_v;

    for (genvar i = 0; i < L; i++) begin : g_lane
        ma_lane #(.W(W)) u_lane (
            .in_op  (in_op[MA_OP_W*i +: MA_OP_W]),
            .m      (in_modulus),
            .a      (in_a[i*W +: W]),
            .b      (in_b[i*W +: W]),
            .raw    (lane_raw[i]),
            .rerr   (lane_rerr[i]),
            .s1_op  (s1_op[MA_OP_W*i +: MA_OP_W]),
            .s1_m   (s1_m),
            .s1_raw (s1_raw[i]),
            .res    (lane_res[i*W +: W])
        );
    end

    // A stage only overwrites its payload when a real beat moves in, so a stalled
    // or drained stage keeps its last contents and the outputs stay stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            s1_op    <= '0;
            s1_m     <= '0;
            s1_tag   <= '0;
            s1_raw   <= '0;
            s1_rerr  <= '0;
            out_data <= '0;
            out_tag  <= '0;
            out_rerr <= '0;
        end else begin
            if (s1_load) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_op   <= in_op;
                    s1_m    <= in_modulus;
                    s1_tag  <= in_tag;
                    s1_raw  <= lane_raw;
                    s1_rerr <= lane_rerr;
                end
            end
            if (s2_load) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    out_data <= lane_res;
                    out_tag  <= s1_tag;
                    out_rerr <= s1_rerr;
                end
            end
        end
    end
endmodule

// File: tb/tb_ma_unit_pipe.sv
// tb/tb_ma_unit_pipe.sv - self-checking bench for ma_unit_pipe with a modular-arithmetic scoreboard
module tb_ma_unit_pipe;
    localparam int W  = 54;
    localparam int NL = 4;
    localparam logic [W-1:0] MBIG = 54'h3F_FFFF_FFFF_FFFF;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2*NL-1:0]   in_op = '0;
    logic [W-1:0]      in_modulus = 54'd97;
    logic [W*NL-1:0]   in_a = '0;
    logic [W*NL-1:0]   in_b = '0;
    logic [7:0]        in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [W*NL-1:0]   out_data;
    logic [7:0]        out_tag;
    logic [NL-1:0]     out_rerr;

    typedef struct {
        logic [W*NL-1:0] data;
        logic [W*NL-1:0] dmask;
        logic [NL-1:0]   rerr;
        logic [7:0]      tag;
        int              cyc;
    } beat_t;

    beat_t           q[$];
    int              cyc = 0;
    int              n_cmp = 0;
    int              n_err = 0;
    bit              hold_armed = 0;
    logic [W*NL-1:0] held_data;
    logic [7:0]      held_tag;

    ma_unit_pipe #(.DATA_WIDTH(W), .NUM_LANES(NL), .TAG_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_modulus(in_modulus), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_rerr(out_rerr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W*NL-1:0] p4(input logic [W-1:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [W-1:0] rnd54();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[W-1:0];
    endfunction

    // Modular results straight from the arithmetic definition; lanes flagged as
    // out of range have undefined data and are masked out of the data compare.
    function automatic beat_t model(input logic [2*NL-1:0] ops, input logic [W-1:0] m,
                                   input logic [W*NL-1:0] a, input logic [W*NL-1:0] b,
                                   input logic [7:0] tag);
        beat_t e;
        logic [63:0] av, bv, mv, r;
        logic [1:0] op;
        e.data = '0; e.dmask = '0; e.rerr = '0; e.tag = tag; e.cyc = 0;
        mv = 64'(m);
        for (int i = 0; i < NL; i++) begin
            av = 64'(a[i*W +: W]);
            bv = 64'(b[i*W +: W]);
            op = ops[2*i +: 2];
            case (op)
                2'd0:    r = (av + bv) % mv;
                2'd1:    r = (av + mv - bv) % mv;
                2'd2:    r = (mv - bv) % mv;
                default: r = av;
            endcase
            e.rerr[i] = (av >= mv) || (op != 2'd3 && bv >= mv);
            e.data[i*W +: W] = r[W-1:0];
            if (!e.rerr[i]) e.dmask[i*W +: W] = '1;
        end
        return e;
    endfunction

    task automatic cycle(output bit acc);
        beat_t e, nb;
        bit exp_ov;
        @(negedge clk);
        chk("in_ready", in_ready, (q.size() < 2) || out_ready);
        exp_ov = 0;
        if (q.size() > 0) exp_ov = (cyc >= q[0].cyc + 2);
        chk("out_valid", out_valid, exp_ov);
        if (hold_armed) begin
            chk("hold_data", out_data, held_data);
            chk("hold_tag", out_tag, held_tag);
        end
        hold_armed = out_valid && !out_ready;
        held_data = out_data;
        held_tag = out_tag;
        if (out_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("out_data", out_data & e.dmask, e.data & e.dmask);
            chk("out_tag", out_tag, e.tag);
            chk("out_rerr", out_rerr, e.rerr);
        end
        acc = in_valid && in_ready;
        if (acc) begin
            nb = model(in_op, in_modulus, in_a, in_b, in_tag);
            nb.cyc = cyc;
            q.push_back(nb);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [2*NL-1:0] ops, input logic [W-1:0] m,
                       input logic [W*NL-1:0] a, input logic [W*NL-1:0] b, input logic [7:0] tag);
        bit acc = 0;
        in_op = ops; in_modulus = m; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        for (int k = 0; k < 20 && !acc; k++) cycle(acc);
        if (!acc) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Issue into an empty pipe with out_ready high; result must be there two edges later.
    task automatic direct(input string name, input logic [2*NL-1:0] ops, input logic [W-1:0] m,
                          input logic [W*NL-1:0] a, input logic [W*NL-1:0] b, input logic [7:0] tag,
                          input logic [W*NL-1:0] exp_d, input logic [W*NL-1:0] dmask,
                          input logic [NL-1:0] exp_r);
        bit acc;
        out_ready = 1'b1;
        put(ops, m, a, b, tag);
        cycle(acc);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_data"}, out_data & dmask, exp_d & dmask);
        chk({name, "_rerr"}, out_rerr, exp_r);
        chk({name, "_tag"}, out_tag, tag);
        cycle(acc);
    endtask

    task automatic drain();
        bit acc;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && q.size() > 0; k++) cycle(acc);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        bit acc;
        bit saw_stall;
        int nb;
        logic [W-1:0] m;
        logic [W*NL-1:0] a, b;
        logic [2*NL-1:0] ops;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_rerr", out_rerr, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);

        direct("t1_add", 8'h00, 54'd97, p4(50, 96, 0, 48), p4(60, 1, 0, 48), 8'h11,
               p4(13, 0, 0, 96), '1, 4'b0000);
        direct("t2_sub", 8'h55, 54'd97, p4(10, 20, 0, 5), p4(20, 10, 96, 5), 8'h12,
               p4(87, 10, 1, 0), '1, 4'b0000);
        direct("t2_neg", 8'hEA, 54'd97, p4(3, 3, 3, 42), p4(0, 1, 96, 7), 8'h13,
               p4(0, 96, 1, 42), '1, 4'b0000);
        direct("t3_wide", 8'hF4, MBIG, p4(MBIG - 1, 0, 7, 0), p4(MBIG - 1, MBIG - 1, 0, 0), 8'h14,
               p4(MBIG - 2, 1, 7, 0), '1, 4'b0000);
        direct("t5_rerr", 8'h3C, 54'd97, p4(97, 100, 5, 1), p4(1, 5, 100, 1), 8'h15,
               p4(0, 0, 5, 2), p4(0, 0, '1, '1), 4'b0011);
        drain();

        saw_stall = 0;
        nb = 1;
        for (int k = 0; k < 40 && (nb <= 6 || q.size() > 0); k++) begin
            out_ready = !(k >= 2 && k <= 4);
            in_valid = (nb <= 6);
            in_tag = 8'(nb);
            in_modulus = 54'd97;
            in_op = 8'($urandom);
            for (int i = 0; i < NL; i++) begin
                in_a[i*W +: W] = 54'($urandom_range(0, 96));
                in_b[i*W +: W] = 54'($urandom_range(0, 96));
            end
            if (!in_ready) saw_stall = 1;
            cycle(acc);
            if (acc) nb++;
        end
        chk("t4_stall_seen", saw_stall, 1);
        chk("t4_all_sent", nb, 7);
        drain();

        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 2))
                0:       m = 54'd97;
                1:       m = MBIG;
                default: begin m = rnd54(); if (m < 2) m = 2; end
            endcase
            ops = 8'($urandom);
            for (int i = 0; i < NL; i++) begin
                a[i*W +: W] = ($urandom_range(0, 15) == 0) ? rnd54() : rnd54() % m;
                b[i*W +: W] = ($urandom_range(0, 15) == 0) ? rnd54() : rnd54() % m;
                if ($urandom_range(0, 7) == 0) b[i*W +: W] = '0;
                if ($urandom_range(0, 7) == 0) a[i*W +: W] = m - 1;
            end
            in_op = ops; in_modulus = m; in_a = a; in_b = b; in_tag = 8'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle(acc);
        end
        drain();

        out_ready = 1'b0;
        put(8'h00, 54'd97, p4(1, 2, 3, 4), p4(5, 6, 7, 8), 8'hA1);
        put(8'h55, 54'd97, p4(9, 9, 9, 9), p4(1, 2, 3, 4), 8'hA2);
        #3 rst = 1'b0;
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_out_data", out_data, 0);
        chk("t6_out_tag", out_tag, 0);
        chk("t6_out_rerr", out_rerr, 0);
        q.delete();
        hold_armed = 0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_in_ready", in_ready, 1);
        direct("t6_after", 8'h00, 54'd97, p4(90, 1, 2, 3), p4(10, 1, 2, 3), 8'hB0,
               p4(3, 2, 4, 6), '1, 4'b0000);
        drain();
        for (int k = 0; k < 3; k++) cycle(acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
